// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - shared types for the serial-to-parallel deserialiser
package s2p_pkg;

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} s2p_state_t;

endpackage

// File: rtl/s2p_deser.sv
// rtl/s2p_deser.sv - double-buffered 1-bit serial to N-bit parallel deserialiser
// Build option: S2P_MSB_FIRST_EN puts the first received bit in par_data[N-1].
module s2p_deser
  import s2p_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ser_data,
  input  logic         ser_valid,
  output logic         ser_ready,
  output logic [N-1:0] par_data,
  output logic         par_valid,
  input  logic         par_ready
);

  localparam int CNT_W = $clog2(N);

  s2p_state_t       state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [N-1:0]     shift_reg;
  logic [N-1:0]     out_reg;
  logic             out_valid;
  logic [N-1:0]     word;
  logic             bit_acc;
  logic             pop;
  logic             last_bit;
  logic             slot_free;
  logic             load_ser;
  logic             load_shift;

  assign bit_acc    = ser_valid && ser_ready;
  assign pop        = out_valid && par_ready;
  assign last_bit   = (count == CNT_W'(N - 1));
  assign slot_free  = !out_valid || par_ready;
  assign load_ser   = (state == COLLECT) && bit_acc && last_bit && slot_free;
  assign load_shift = (state == FULL) && pop;

`ifdef S2P_MSB_FIRST_EN
  assign word = {shift_reg[N-2:0], ser_data};
`else
  assign word = {ser_data, shift_reg[N-1:1]};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (bit_acc && last_bit && !slot_free) state_nxt = FULL;
      FULL:    if (pop) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    ser_ready = (state == COLLECT);
  end

  // A completed word parks in shift_reg only when the output slot cannot take it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count     <= '0;
      shift_reg <= '0;
      out_reg   <= '0;
      out_valid <= 1'b0;
    end else begin
      if ((state == COLLECT) && bit_acc && !load_ser) begin
        shift_reg <= word;
      end

      if (load_ser || load_shift) begin
        count <= '0;
      end else if ((state == COLLECT) && bit_acc && !last_bit) begin
        count <= count + 1'b1;
      end

      if (load_ser) begin
        out_reg <= word;
      end else if (load_shift) begin
        out_reg <= shift_reg;
      end

      if (load_ser || load_shift) begin
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign par_data  = out_reg;
  assign par_valid = out_valid;

endmodule

// File: tb/tb_s2p_deser.sv
// tb/tb_s2p_deser.sv - directed self-checking bench for s2p_deser (N = 8)
module tb_s2p_deser;

  logic       clk;
  logic       rstn;
  logic       ser_data;
  logic       ser_valid;
  logic       ser_ready;
  logic [7:0] par_data;
  logic       par_valid;
  logic       par_ready;

  int tests = 0;
  int fails = 0;

  s2p_deser #(.N(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .par_data  (par_data),
    .par_valid (par_valid),
    .par_ready (par_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bits are always sent in order w[0], w[1], ... w[7].
  function automatic logic [7:0] exp_word(input logic [7:0] w);
    logic [7:0] r;
`ifdef S2P_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[7-i] = w[i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      ser_data  = w[i];
      ser_valid = 1'b1;
      step();
    end
    ser_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    rstn      = 1'b0;
    ser_data  = 1'b0;
    ser_valid = 1'b0;
    par_ready = 1'b0;
    repeat (2) step();
    check("reset_ser_ready", ser_ready, 1);
    check("reset_par_valid", par_valid, 0);
    check("reset_par_data", par_data, 0);
    rstn = 1'b1;
    step();

    // 1: streaming with consumer always ready, bits 1,0,1,0,0,1,0,1
    par_ready = 1'b1;
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      ser_data  = w[i];
      ser_valid = 1'b1;
      step();
      check("t1_ser_ready", ser_ready, 1);
      if (i == 6) check("t1_no_early_valid", par_valid, 0);
    end
    ser_valid = 1'b0;
    check("t1_par_valid", par_valid, 1);
    check("t1_par_data", par_data, exp_word(8'hA5));
    step();
    check("t1_popped", par_valid, 0);

    // 2: back-pressure fills both buffers
    par_ready = 1'b0;
    send_word(8'h3C);
    check("t2_first_valid", par_valid, 1);
    check("t2_first_data", par_data, exp_word(8'h3C));
    check("t2_ready_after_first", ser_ready, 1);
    send_word(8'hC3);
    check("t2_full_ser_ready", ser_ready, 0);
    check("t2_full_data", par_data, exp_word(8'h3C));
    ser_data  = 1'b1;
    ser_valid = 1'b1;
    step();
    ser_valid = 1'b0;
    check("t2_hold_data", par_data, exp_word(8'h3C));
    check("t2_hold_valid", par_valid, 1);
    check("t2_hold_ser_ready", ser_ready, 0);
    par_ready = 1'b1;
    step();
    par_ready = 1'b0;
    check("t2_second_data", par_data, exp_word(8'hC3));
    check("t2_second_valid", par_valid, 1);
    check("t2_ready_back", ser_ready, 1);
    par_ready = 1'b1;
    step();
    check("t2_drained", par_valid, 0);

    // 3: ser_valid gaps with garbage on ser_data
    w = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      repeat (i % 3) begin
        ser_valid = 1'b0;
        ser_data  = ~w[i];
        step();
      end
      ser_data  = w[i];
      ser_valid = 1'b1;
      step();
      ser_valid = 1'b0;
      if (i == 6) check("t3_no_early_valid", par_valid, 0);
    end
    check("t3_par_valid", par_valid, 1);
    check("t3_par_data", par_data, exp_word(8'h5A));
    step();
    check("t3_popped", par_valid, 0);

    // 4: pop coincides with completion of the next word
    par_ready = 1'b0;
    send_word(8'h11);
    w = 8'h81;
    for (int i = 0; i < 8; i++) begin
      ser_data  = w[i];
      ser_valid = 1'b1;
      if (i == 7) par_ready = 1'b1;
      step();
      check("t4_no_bubble", par_valid, 1);
      if (i < 7) check("t4_old_held", par_data, exp_word(8'h11));
    end
    ser_valid = 1'b0;
    par_ready = 1'b0;
    check("t4_par_data", par_data, exp_word(8'h81));
    check("t4_ser_ready", ser_ready, 1);
    par_ready = 1'b1;
    step();
    check("t4_drained", par_valid, 0);

    // 5: reset in the middle of a word
    par_ready = 1'b0;
    send_word(8'h42);
    for (int i = 0; i < 3; i++) begin
      ser_data  = 1'b1;
      ser_valid = 1'b1;
      step();
    end
    ser_valid = 1'b0;
    rstn = 1'b0;
    #2;
    check("t5_rst_par_valid", par_valid, 0);
    check("t5_rst_ser_ready", ser_ready, 1);
    check("t5_rst_par_data", par_data, 0);
    step();
    rstn = 1'b1;
    par_ready = 1'b1;
    step();
    send_word(8'hF0);
    check("t5_par_valid", par_valid, 1);
    check("t5_par_data", par_data, exp_word(8'hF0));
    step();

    // 6: bit order, bits 1,0,0,1,0,1,1,0
    send_word(8'h69);
    check("t6_par_valid", par_valid, 1);
`ifdef S2P_MSB_FIRST_EN
    check("t6_par_data", par_data, 8'h96);
`else
    check("t6_par_data", par_data, 8'h69);
`endif
    step();
    check("t6_popped", par_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
